// File: rtl/if_pkg.sv
// if_pkg: shared fetch FSM state encoding and the NOP word substituted on a misaligned fetch
package if_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} fetch_state_e;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: one-entry instruction/pc(/fault) holding register between imem and ID
//   clk, reset (sync, active-low); load_i/clear_i/consume_i control; instr_i/pc_i(/fault_i) data in;
//   instr_o/pc_o/valid_o(/fault_o) entry out. Fault field exists only with IF_MISALIGN_TRAP_EN.
module if_fetch_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic            consume_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
`ifdef IF_MISALIGN_TRAP_EN
  input  logic            fault_i,
  output logic            fault_o,
`endif
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            valid_o
);
  logic [XLEN-1:0] instr_q, pc_q;
  logic            valid_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load_i && !clear_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
      // clear (flush) beats load; load beats consume so back-to-back entries stream
      valid_q <= clear_i ? 1'b0 : load_i ? 1'b1 : consume_i ? 1'b0 : valid_q;
    end
  end
`ifdef IF_MISALIGN_TRAP_EN
  logic fault_q;
  always_ff @(posedge clk) begin
    if (!reset) fault_q <= 1'b0;
    else fault_q <= clear_i ? 1'b0 : load_i ? fault_i : consume_i ? 1'b0 : fault_q;
  end
  assign fault_o = fault_q;
`endif
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage fetch controller, one imem request outstanding, one buffered instruction
//   clk, reset (sync, active-low); pc in / pc_enable out to the PC register; flush, stall_in from
//   later stages; imem_req/imem_addr/imem_ack/imem_rdata memory handshake; instr_out/instr_pc/
//   instr_valid to IF/ID. IF_MISALIGN_TRAP_EN adds instr_fault and traps misaligned PCs with a NOP.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_enable,
  input  logic            flush,
  input  logic            stall_in,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
`ifdef IF_MISALIGN_TRAP_EN
  output logic            instr_fault,
`endif
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d, pc_al, ld_instr, ld_pc;
  logic            consume, can_issue, load, req, pen;
`ifdef IF_MISALIGN_TRAP_EN
  logic            ld_fault;
`endif
  assign consume   = instr_valid & ~stall_in;
  assign can_issue = (~instr_valid | consume) & ~flush;
  assign pc_al     = pc & ~XLEN'(3);
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req        = 1'b0;
    imem_addr  = pc_al;
    pen        = flush;
    load       = 1'b0;
    ld_instr   = imem_rdata;
    ld_pc      = pc_al;
`ifdef IF_MISALIGN_TRAP_EN
    ld_fault   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef IF_MISALIGN_TRAP_EN
        // misaligned PC: no memory access, hand ID a NOP tagged as faulting and hold the PC
        if (can_issue && pc[1:0] != 2'b00) begin
          load     = 1'b1;
          ld_instr = NOP_INSTR;
          ld_pc    = pc;
          ld_fault = 1'b1;
        end else
`endif
        if (can_issue) begin
          req = 1'b1;
          if (imem_ack) begin
            load = 1'b1;
            pen  = 1'b1;
          end else begin
            req_addr_d = pc_al;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        req       = 1'b1;
        imem_addr = req_addr_q;
        ld_pc     = req_addr_q;
        if (imem_ack) begin
          load    = ~flush;
          pen     = 1'b1;
          state_d = S_IDLE;
        end else if (flush) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // the abandoned response still has to be absorbed before a new request
        req       = 1'b1;
        imem_addr = req_addr_q;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
    end
  end
  assign imem_req  = req & reset;
  assign pc_enable = pen & reset;
  if_fetch_buf #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .clear_i   (flush),
    .consume_i (consume),
    .instr_i   (ld_instr),
    .pc_i      (ld_pc),
`ifdef IF_MISALIGN_TRAP_EN
    .fault_i   (ld_fault),
    .fault_o   (instr_fault),
`endif
    .instr_o   (instr_out),
    .pc_o      (instr_pc),
    .valid_o   (instr_valid)
  );
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed vector table plus hand sequences for if_fetch_ctrl
module tb_if_fetch_ctrl;
  logic        clk = 1'b0, reset, flush, stall_in, imem_ack, pc_enable, imem_req, instr_valid;
  logic [31:0] pc, imem_addr, imem_rdata, instr_out, instr_pc;
`ifdef IF_MISALIGN_TRAP_EN
  logic        instr_fault;
  localparam logic [31:0] PMIS = 32'h400;
`else
  localparam logic [31:0] PMIS = 32'h402;
`endif
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  if_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_enable  (pc_enable),
    .flush      (flush),
    .stall_in   (stall_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
`ifdef IF_MISALIGN_TRAP_EN
    .instr_fault(instr_fault),
`endif
    .instr_out  (instr_out),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid)
  );
  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        fl, st, ack;
    logic [31:0] rd;
    logic        req;
    logic [31:0] addr;
    logic        pen, val;
    logic [31:0] iout, ipc;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(input logic r, input logic [31:0] p, input logic f, s, a,
                              input logic [31:0] d, input logic rq, input logic [31:0] ad,
                              input logic pe, v, input logic [31:0] io, ip);
    vec_t x;
    x.rst = r; x.pc = p; x.fl = f; x.st = s; x.ack = a; x.rd = d;
    x.req = rq; x.addr = ad; x.pen = pe; x.val = v; x.iout = io; x.ipc = ip;
    return x;
  endfunction
  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask
  task automatic drive(input logic r, input logic [31:0] p, input logic f, s, a, input logic [31:0] d);
    reset = r; pc = p; flush = f; stall_in = s; imem_ack = a; imem_rdata = d;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    // reset state
    tbl.push_back(mk(0, 32'h000, 0, 0, 0, 32'h0,        0, 32'h000, 0, 0, 32'h0,        32'h000));
    // zero-wait streaming
    tbl.push_back(mk(1, 32'h000, 0, 0, 1, 32'h11110000, 1, 32'h000, 1, 0, 32'h0,        32'h000));
    tbl.push_back(mk(1, 32'h004, 0, 0, 1, 32'h11110004, 1, 32'h004, 1, 1, 32'h11110000, 32'h000));
    tbl.push_back(mk(1, 32'h008, 0, 0, 1, 32'h11110008, 1, 32'h008, 1, 1, 32'h11110004, 32'h004));
    // 3-wait memory at 0x10
    tbl.push_back(mk(1, 32'h010, 0, 0, 0, 32'h0,        1, 32'h010, 0, 1, 32'h11110008, 32'h008));
    tbl.push_back(mk(1, 32'h010, 0, 0, 0, 32'h0,        1, 32'h010, 0, 0, 32'h11110008, 32'h008));
    tbl.push_back(mk(1, 32'h010, 0, 0, 0, 32'h0,        1, 32'h010, 0, 0, 32'h11110008, 32'h008));
    tbl.push_back(mk(1, 32'h010, 0, 0, 1, 32'h22220010, 1, 32'h010, 1, 0, 32'h11110008, 32'h008));
    // stall 4 cycles, release issues immediately
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 32'h014, 0, 1, 0, 32'h0,      0, 32'h014, 0, 1, 32'h22220010, 32'h010));
    tbl.push_back(mk(1, 32'h014, 0, 0, 1, 32'h22220014, 1, 32'h014, 1, 1, 32'h22220010, 32'h010));
    // flush during wait -> drain, then target 0x100
    tbl.push_back(mk(1, 32'h020, 0, 0, 0, 32'h0,        1, 32'h020, 0, 1, 32'h22220014, 32'h014));
    tbl.push_back(mk(1, 32'h020, 1, 0, 0, 32'h0,        1, 32'h020, 1, 0, 32'h22220014, 32'h014));
    tbl.push_back(mk(1, 32'h100, 0, 0, 0, 32'h0,        1, 32'h020, 0, 0, 32'h22220014, 32'h014));
    tbl.push_back(mk(1, 32'h100, 0, 0, 1, 32'hdeadbeef, 1, 32'h020, 0, 0, 32'h22220014, 32'h014));
    tbl.push_back(mk(1, 32'h100, 0, 0, 1, 32'h33330100, 1, 32'h100, 1, 0, 32'h22220014, 32'h014));
    // flush and ack together: no capture
    tbl.push_back(mk(1, 32'h104, 0, 0, 0, 32'h0,        1, 32'h104, 0, 1, 32'h33330100, 32'h100));
    tbl.push_back(mk(1, 32'h104, 1, 0, 1, 32'hdeadbeef, 1, 32'h104, 1, 0, 32'h33330100, 32'h100));
    tbl.push_back(mk(1, 32'h200, 0, 0, 0, 32'h0,        1, 32'h200, 0, 0, 32'h33330100, 32'h100));
    // reset while waiting
    tbl.push_back(mk(0, 32'h200, 0, 0, 0, 32'h0,        0, 32'h200, 0, 0, 32'h33330100, 32'h100));
    tbl.push_back(mk(1, 32'h300, 0, 0, 1, 32'h44440300, 1, 32'h300, 1, 0, 32'h0,        32'h000));
    // flush in idle with a full, stalled buffer
    tbl.push_back(mk(1, 32'h304, 1, 1, 0, 32'h0,        0, 32'h304, 1, 1, 32'h44440300, 32'h300));
    // address alignment (low pc bits dropped in the default build)
    tbl.push_back(mk(1, PMIS,    0, 0, 0, 32'h0,        1, 32'h400, 0, 0, 32'h44440300, 32'h300));
    tbl.push_back(mk(1, PMIS,    0, 0, 1, 32'h55550400, 1, 32'h400, 1, 0, 32'h44440300, 32'h300));
    tbl.push_back(mk(1, 32'h404, 0, 1, 0, 32'h0,        0, 32'h404, 0, 1, 32'h55550400, 32'h400));
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].pc, tbl[i].fl, tbl[i].st, tbl[i].ack, tbl[i].rd);
      @(negedge clk);
      chk("imem_req",    i, 32'(imem_req),    32'(tbl[i].req));
      chk("imem_addr",   i, imem_addr,        tbl[i].addr);
      chk("pc_enable",   i, 32'(pc_enable),   32'(tbl[i].pen));
      chk("instr_valid", i, 32'(instr_valid), 32'(tbl[i].val));
      chk("instr_out",   i, instr_out,        tbl[i].iout);
      chk("instr_pc",    i, instr_pc,         tbl[i].ipc);
      tick();
    end
    // long wait: address held while the PC input moves
    drive(1, 32'h500, 0, 0, 0, 0);
    @(negedge clk);
    chk("h_issue_req", 100, 32'(imem_req), 32'h1);
    chk("h_issue_addr", 100, imem_addr, 32'h500);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h504 + 32'(4 * k), 0, 0, 0, 0);
      @(negedge clk);
      chk("h_wait_req", 101 + k, 32'(imem_req), 32'h1);
      chk("h_wait_addr", 101 + k, imem_addr, 32'h500);
      chk("h_wait_pen", 101 + k, 32'(pc_enable), 32'h0);
      tick();
    end
    drive(1, 32'h504, 0, 0, 1, 32'h66660500);
    @(negedge clk);
    chk("h_ack_pen", 110, 32'(pc_enable), 32'h1);
    tick();
    drive(1, 32'h504, 0, 1, 0, 0);
    @(negedge clk);
    chk("h_cap_valid", 111, 32'(instr_valid), 32'h1);
    chk("h_cap_out", 111, instr_out, 32'h66660500);
    chk("h_cap_pc", 111, instr_pc, 32'h500);
    chk("h_cap_req", 111, 32'(imem_req), 32'h0);
    tick();
`ifdef IF_MISALIGN_TRAP_EN
    drive(1, 32'h6, 0, 0, 0, 0);
    @(negedge clk);
    chk("m_req", 120, 32'(imem_req), 32'h0);
    chk("m_pen", 120, 32'(pc_enable), 32'h0);
    chk("m_fault0", 120, 32'(instr_fault), 32'h0);
    tick();
    drive(1, 32'h6, 0, 1, 0, 0);
    @(negedge clk);
    chk("m_valid", 121, 32'(instr_valid), 32'h1);
    chk("m_out", 121, instr_out, 32'h00000013);
    chk("m_pc", 121, instr_pc, 32'h6);
    chk("m_fault", 121, 32'(instr_fault), 32'h1);
    tick();
    drive(1, 32'h6, 1, 1, 0, 0);
    tick();
    drive(1, 32'h6, 0, 1, 0, 0);
    @(negedge clk);
    chk("m_clr_valid", 122, 32'(instr_valid), 32'h0);
    chk("m_clr_fault", 122, 32'(instr_fault), 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
